// File: rtl/bsort_pkg.sv
// bsort_pkg: shared sizes and FSM state encoding for the bubble-sort accelerator
package bsort_pkg;
  localparam int N_ELEM = 100;
  localparam int DATA_W = 32;
  localparam int SLV_ADDR_W = 10;
  localparam int SLV_DATA_W = 64;
  localparam int SLV_SIZE_W = 7;
  localparam int N_CH = 2;
  localparam int IDX_W = 7;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_INIT = 3'd1;
  localparam state_t S_PASS = 3'd2;
  localparam state_t S_RD   = 3'd3;
  localparam state_t S_CMP  = 3'd4;
  localparam state_t S_DONE = 3'd5;
endpackage

// File: rtl/bsort_if.sv
// bsort_if: two-channel slave access port to the sort array
interface bsort_if;
  import bsort_pkg::*;
  logic [N_CH-1:0] S_oe_ram;
  logic [N_CH-1:0] S_we_ram;
  logic [N_CH*SLV_ADDR_W-1:0] S_addr_ram;
  logic [N_CH*SLV_DATA_W-1:0] S_Wdata_ram;
  logic [N_CH*SLV_SIZE_W-1:0] S_data_ram_size;
  logic [N_CH*SLV_DATA_W-1:0] Sout_Rdata_ram;
  logic [N_CH-1:0] Sout_DataRdy;
  modport master (output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                  input Sout_Rdata_ram, Sout_DataRdy);
  modport slave (input S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                 output Sout_Rdata_ram, Sout_DataRdy);
endinterface

// File: rtl/bsort_dpram.sv
// bsort_dpram: 100x32 true dual-port RAM, registered read; port b wins a same-word write
module bsort_dpram
  import bsort_pkg::*;
(
  input  logic              clock,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [IDX_W-1:0]  addr_a,
  input  logic [IDX_W-1:0]  addr_b,
  input  logic [DATA_W-1:0] wd_a,
  input  logic [DATA_W-1:0] wd_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);
  logic [DATA_W-1:0] mem [N_ELEM];
  always_ff @(posedge clock) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end
endmodule

// File: rtl/bsort_main.sv
// bsort_main: initialise a 100-word array descending, bubble-sort it ascending, pulse done
module bsort_main
  import bsort_pkg::*;
#(
  parameter int MEM_var_26078_26084 = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic start_port,
  output logic done_port,
  bsort_if.slave s
);
  localparam logic [SLV_ADDR_W-1:0] BASE = SLV_ADDR_W'(MEM_var_26078_26084);
  localparam logic [SLV_ADDR_W-1:0] TOP = SLV_ADDR_W'(MEM_var_26078_26084 + N_ELEM * 4);
  state_t state;
  logic [IDX_W-1:0] k, i, j;
  logic swapped, busy, gt;
  logic [N_CH-1:0] hit, wr, rd_ack, wr_ack;
  logic [SLV_ADDR_W-1:0] addr [N_CH];
  logic [SLV_ADDR_W-1:0] off [N_CH];
  logic [IDX_W-1:0] sidx [N_CH];
  logic [DATA_W-1:0] swd [N_CH];
  logic we_a, we_b;
  logic [IDX_W-1:0] ad_a, ad_b;
  logic [DATA_W-1:0] wd_a, wd_b, q_a, q_b;
  logic unused_bits;
  assign busy = state != S_IDLE;
  assign gt = $signed(q_a) > $signed(q_b);
  assign done_port = state == S_DONE;
  always_comb
    for (int c = 0; c < N_CH; c++) begin
      addr[c] = s.S_addr_ram[c*SLV_ADDR_W +: SLV_ADDR_W];
      off[c] = addr[c] - BASE;
      sidx[c] = off[c][IDX_W+1:2];
      swd[c] = s.S_Wdata_ram[c*SLV_DATA_W +: DATA_W];
      hit[c] = !busy && addr[c] >= BASE && addr[c] < TOP && (s.S_oe_ram[c] || s.S_we_ram[c])
               && s.S_data_ram_size[c*SLV_SIZE_W +: SLV_SIZE_W] == SLV_SIZE_W'(DATA_W);
      wr[c] = hit[c] && s.S_we_ram[c];
    end
  // slave ch0 shares RAM port a with the FSM, ch1 shares port b
  always_comb begin
    ad_a = busy ? (state == S_INIT ? k : j) : sidx[0];
    ad_b = busy ? j + 1'b1 : sidx[1];
    we_a = busy ? state == S_INIT || (state == S_CMP && gt) : wr[0];
    we_b = busy ? state == S_CMP && gt : wr[1];
    wd_a = busy ? (state == S_INIT ? -DATA_W'(k) : q_b) : swd[0];
    wd_b = busy ? q_a : swd[1];
  end
  bsort_dpram u_ram (
    .clock(clock), .we_a(we_a), .we_b(we_b), .addr_a(ad_a), .addr_b(ad_b),
    .wd_a(wd_a), .wd_b(wd_b), .q_a(q_a), .q_b(q_b)
  );
  assign s.Sout_DataRdy = rd_ack | wr_ack;
  assign s.Sout_Rdata_ram = {rd_ack[1] ? SLV_DATA_W'(q_b) : {SLV_DATA_W{1'b0}},
                             rd_ack[0] ? SLV_DATA_W'(q_a) : {SLV_DATA_W{1'b0}}};
  assign unused_bits = ^{off[0][SLV_ADDR_W-1], off[0][1:0], off[1][SLV_ADDR_W-1], off[1][1:0],
                         s.S_Wdata_ram[2*SLV_DATA_W-1 -: DATA_W], s.S_Wdata_ram[SLV_DATA_W-1 -: DATA_W]};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      k <= '0;
      i <= '0;
      j <= '0;
      swapped <= 1'b0;
      rd_ack <= '0;
      wr_ack <= '0;
    end else begin
      rd_ack <= hit & ~s.S_we_ram;
      wr_ack <= wr;
      case (state)
        S_IDLE: if (start_port) begin
          state <= S_INIT;
          k <= '0;
          i <= '0;
        end
        S_INIT: begin
          k <= k + 1'b1;
          if (k == IDX_W'(N_ELEM - 1)) state <= S_PASS;
        end
        S_PASS: begin
          j <= '0;
          swapped <= 1'b0;
          state <= (i == IDX_W'(N_ELEM - 1) || (i != '0 && !swapped)) ? S_DONE : S_RD;
        end
        S_RD: state <= S_CMP;
        S_CMP: begin
          if (gt) swapped <= 1'b1;
          if (j < IDX_W'(N_ELEM - 2) - i) begin
            j <= j + 1'b1;
            state <= S_RD;
          end else begin
            i <= i + 1'b1;
            state <= S_PASS;
          end
        end
        S_DONE: begin
          i <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_bsort_main.sv
// tb_bsort_main: directed checks of sort latency, abort on reset and the slave port
module tb_bsort_main;
  import bsort_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_port = 1'b0;
  logic done_port;
  int checks = 0;
  int errors = 0;
  bsort_if bus ();
  bsort_main dut (.clock(clock), .reset(reset), .start_port(start_port), .done_port(done_port), .s(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic clr();
    bus.S_oe_ram = '0;
    bus.S_we_ram = '0;
    bus.S_addr_ram = '0;
    bus.S_Wdata_ram = '0;
    bus.S_data_ram_size = '0;
  endtask
  task automatic set_ch(input int c, input logic oe, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [6:0] sz);
    bus.S_oe_ram[c] = oe;
    bus.S_we_ram[c] = we;
    bus.S_addr_ram[c*10 +: 10] = a;
    bus.S_Wdata_ram[c*64 +: 64] = {32'hDEAD_BEEF, d};
    bus.S_data_ram_size[c*7 +: 7] = sz;
  endtask
  task automatic access(input int c, input logic oe, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [6:0] sz,
                        output logic [63:0] q, output logic [1:0] rdy);
    set_ch(c, oe, we, a, d, sz);
    step();
    q = bus.Sout_Rdata_ram[c*64 +: 64];
    rdy = bus.Sout_DataRdy;
    clr();
  endtask
  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      step();
      n++;
    end while (!done_port && n < 20000);
  endtask
  task automatic check_sorted(input string tag);
    logic [63:0] q;
    logic [1:0] r;
    for (int x = 0; x < 100; x++) begin
      access(x % 2, 1'b1, 1'b0, 10'(256 + 4 * x), 32'd0, 7'd32, q, r);
      check($sformatf("%s[%0d]", tag, x), q, {32'd0, 32'(x - 99)});
    end
  endtask
  initial begin
    logic [63:0] q;
    logic [1:0] r;
    int n;
    int p;
    clr();
    repeat (3) @(posedge clock);
    #1;
    check("rst_done", 64'(done_port), 64'd0);
    check("rst_rdy", 64'(bus.Sout_DataRdy), 64'd0);
    check("rst_rdata_lo", bus.Sout_Rdata_ram[63:0], 64'd0);
    check("rst_rdata_hi", bus.Sout_Rdata_ram[127:64], 64'd0);
    reset = 1'b0;
    step();
    start_port = 1'b1;
    step();
    start_port = 1'b0;
    p = 0;
    repeat (5000) begin step(); p += int'(done_port); end
    reset = 1'b1;
    step();
    p += int'(done_port);
    step();
    reset = 1'b0;
    repeat (200) begin step(); p += int'(done_port); end
    check("abort_no_done", 64'(p), 64'd0);
    access(0, 1'b1, 1'b0, 10'd256, 32'd0, 7'd32, q, r);
    check("abort_idle_rdy", 64'(r), 64'd1);
    start_port = 1'b1;
    step();
    start_port = 1'b0;
    wait_done(0, n);
    check("latency1", 64'(n), 64'd10100);
    step();
    check("done_width", 64'(done_port), 64'd0);
    p = 0;
    repeat (100) begin step(); p += int'(done_port); end
    check("no_second_done", 64'(p), 64'd0);
    set_ch(0, 1'b1, 1'b0, 10'd256, 32'd0, 7'd32);
    set_ch(1, 1'b1, 1'b0, 10'd652, 32'd0, 7'd32);
    step();
    check("rd_ch0", bus.Sout_Rdata_ram[63:0], 64'h0000_0000_FFFF_FF9D);
    check("rd_ch1", bus.Sout_Rdata_ram[127:64], 64'd0);
    check("rd_rdy", 64'(bus.Sout_DataRdy), 64'd3);
    clr();
    check_sorted("sort1");
    for (int x = 0; x < 100; x++) begin
      access(x % 2, 1'b0, 1'b1, 10'(256 + 4 * x), 32'(x), 7'd32, q, r);
      if (x < 2) begin
        check($sformatf("wr_rdy%0d", x), 64'(r), 64'(1 << x));
        check($sformatf("wr_rdata%0d", x), q, 64'd0);
      end
    end
    access(1, 1'b1, 1'b0, 10'd276, 32'd0, 7'd32, q, r);
    check("wr_readback5", q, 64'd5);
    start_port = 1'b1;
    step();
    start_port = 1'b0;
    access(0, 1'b1, 1'b0, 10'd256, 32'd0, 7'd32, q, r);
    check("busy_rd_rdy", 64'(r), 64'd0);
    check("busy_rd_rdata", q, 64'd0);
    access(1, 1'b0, 1'b1, 10'd256, 32'd55, 7'd32, q, r);
    check("busy_wr_rdy", 64'(r), 64'd0);
    start_port = 1'b1;
    wait_done(2, n);
    start_port = 1'b0;
    check("latency2", 64'(n), 64'd10100);
    step();
    check_sorted("sort2");
    access(0, 1'b1, 1'b0, 10'd252, 32'd0, 7'd32, q, r);
    check("oow_lo_rdy", 64'(r), 64'd0);
    check("oow_lo_rdata", q, 64'd0);
    access(1, 1'b0, 1'b1, 10'd656, 32'd77, 7'd32, q, r);
    check("oow_hi_rdy", 64'(r), 64'd0);
    access(0, 1'b0, 1'b1, 10'd256, 32'd123, 7'd16, q, r);
    check("size16_wr_rdy", 64'(r), 64'd0);
    access(1, 1'b1, 1'b0, 10'd652, 32'd0, 7'd16, q, r);
    check("size16_rd_rdy", 64'(r), 64'd0);
    check("size16_rd_rdata", q, 64'd0);
    access(1, 1'b1, 1'b0, 10'd259, 32'd0, 7'd32, q, r);
    check("unaligned_rd", q, 64'h0000_0000_FFFF_FF9D);
    check("unaligned_rdy", 64'(r), 64'd2);
    access(0, 1'b1, 1'b0, 10'd652, 32'd0, 7'd32, q, r);
    check("hi_word_kept", q, 64'd0);
    access(0, 1'b1, 1'b1, 10'd260, 32'd42, 7'd32, q, r);
    check("oe_we_rdy", 64'(r), 64'd1);
    check("oe_we_rdata", q, 64'd0);
    access(0, 1'b1, 1'b0, 10'd260, 32'd0, 7'd32, q, r);
    check("oe_we_readback", q, 64'd42);
    set_ch(0, 1'b0, 1'b1, 10'd300, 32'd5, 7'd32);
    set_ch(1, 1'b0, 1'b1, 10'd300, 32'd7, 7'd32);
    step();
    check("dual_wr_rdy", 64'(bus.Sout_DataRdy), 64'd3);
    clr();
    access(0, 1'b1, 1'b0, 10'd300, 32'd0, 7'd32, q, r);
    check("dual_wr_ch1_wins", q, 64'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
